periph_bus_arbiter: RTL and testbench
=====================================

// Module: periph_bus_arbiter
// PURPOSE
//  Shares one 8-bit memory-mapped peripheral port between two requesters: A (CPU load/store) and B (debug/DMA).
//  The port is the GPIO/peripheral request/DV bus.
//  Round-robin grant, one transaction in flight, address/data/write captured at grant.
//  The peripheral response data and DV pulse are routed back to the granted requester only.
// PARAMETERS
//  ADDR_W          12  address width on all sides
//  DATA_W          8   data width on all sides
//  TIMEOUT_CYCLES  15  WAIT cycles before forced completion (only with PERIPH_TIMEOUT_EN); >=1
// PORTS
//  i_clk          in   1       clock, all logic on rising edge
//  i_rst_n        in   1       asynchronous active-low reset
//  i_a_request    in   1       A transaction request, level, held until o_a_data_DV
//  i_a_write      in   1       A: 1=write, 0=read
//  i_a_address    in   ADDR_W  A address
//  i_a_data       in   DATA_W  A write data
//  o_a_data       out  DATA_W  A read data, valid with o_a_data_DV
//  o_a_data_DV    out  1       A completion, 1-cycle pulse
//  i_b_*/o_b_*    -    -       same six signals for requester B
//  o_p_request    out  1       peripheral request, 1-cycle pulse
//  o_p_write      out  1       peripheral write strobe qualifier
//  o_p_address    out  ADDR_W  peripheral address, held from ISSUE through DONE
//  o_p_data       out  DATA_W  peripheral write data, held same as address
//  i_p_data       in   DATA_W  peripheral read data, sampled when i_p_data_DV=1
//  i_p_data_DV    in   1       peripheral completion pulse
//  o_timeout      out  1       sticky timeout flag; 0 when macro absent
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=B, every output 0, timeout counter 0.
//  States:
//   IDLE  -> ISSUE when any request is high.
//            Both high: grant the requester != last_grant. One high: grant it.
//            Latch write/address/data of winner into o_p_*; last_grant<=winner.
//   ISSUE -> o_p_request=1 for exactly this cycle -> WAIT.
//   WAIT  -> on i_p_data_DV: capture i_p_data into winner's o_x_data, pulse winner's o_x_data_DV next cycle -> DONE.
//   DONE  -> o_x_data_DV=1 this cycle only -> IDLE.
//            Requester must drop its request in the cycle after DV; it is resampled in IDLE.
//  Latency: request seen at cycle 0, o_p_request at 1; 1-cycle peripheral DV at 2; o_x_data_DV at 3.
//           Minimum spacing between transactions: 4 cycles.
//  o_x_data retains last value until next completion for that requester; write completions return i_p_data as sampled.
//  Non-granted requester's o_x_data_DV never pulses; its request simply waits (no drop, no starvation).
//  i_p_data_DV outside WAIT is ignored (no state change, no output).
//  i_p_data_DV in the same cycle as ISSUE is ignored; WAIT is entered regardless.
//  Requester inputs changing after grant do not affect the transaction.
//  A request dropped mid-transaction still completes and pulses DV.
//  Reset asserted in any state: immediate return to reset values; the in-flight transaction is abandoned, no DV.
// CONFIGURATION
//  PERIPH_TIMEOUT_EN defined:
//   - Counter runs in WAIT. After TIMEOUT_CYCLES cycles with no DV: winner gets o_x_data={DATA_W{1'b1}} and o_x_data_DV as normal completion; o_timeout<=1 (sticky until reset).
//   - DV and timeout in same cycle: DV wins, no flag.
//  PERIPH_TIMEOUT_EN undefined: WAIT is unbounded; o_timeout tied 0; no counter logic.
// TESTING
//  A read addr 0, peripheral returns 0x5A one cycle after pulse -> o_p_request@1, o_a_data=0x5A & o_a_data_DV@3, o_b_data_DV stays 0.
//  A and B both request at cycle 0 (A write 0x0C to addr 1, B read addr 0), both held -> A served first (last_grant=B at reset), B issued at cycle 5, strict alternation while both held.
//  B held continuously with new request each completion, A idle -> B served every 4 cycles, never blocked by last_grant.
//  i_p_data_DV pulsed while IDLE and during ISSUE -> no o_x_data_DV, state sequence unchanged.
//  i_rst_n low during WAIT -> all outputs 0 immediately; late peripheral DV after release ignored; next A request served normally.
//  PERIPH_TIMEOUT_EN, peripheral silent -> after 15 WAIT cycles o_a_data=0xFF, o_a_data_DV=1, o_timeout=1 stays set; without macro bench waits 100 cycles with no DV.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares one peripheral request/DV port between requesters A and B.
// Round-robin grant, one transaction in flight, winner's write/address/data latched at grant.
// Optional feature macro PERIPH_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES cycles and forces an
// all-ones completion plus a sticky o_timeout flag when the peripheral stays silent.

module periph_bus_arbiter #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // requester A
  input  logic              i_a_request,
  input  logic              i_a_write,
  input  logic [ADDR_W-1:0] i_a_address,
  input  logic [DATA_W-1:0] i_a_data,
  output logic [DATA_W-1:0] o_a_data,
  output logic              o_a_data_DV,
  // requester B
  input  logic              i_b_request,
  input  logic              i_b_write,
  input  logic [ADDR_W-1:0] i_b_address,
  input  logic [DATA_W-1:0] i_b_data,
  output logic [DATA_W-1:0] o_b_data,
  output logic              o_b_data_DV,
  // peripheral side
  output logic              o_p_request,
  output logic              o_p_write,
  output logic [ADDR_W-1:0] o_p_address,
  output logic [DATA_W-1:0] o_p_data,
  input  logic [DATA_W-1:0] i_p_data,
  input  logic              i_p_data_DV,
  output logic              o_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  // 1 = B. The last grant is also the owner of the transaction in flight.
  logic                last_q, last_d;
  logic                p_write_q, p_write_d;
  logic [ADDR_W-1:0]   p_address_q, p_address_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic [DATA_W-1:0]   b_data_q, b_data_d;
  logic                complete;
  logic [DATA_W-1:0]   comp_data;
  logic                expired;

`ifdef PERIPH_TIMEOUT_EN
  localparam int unsigned      CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // Last WAIT cycle of the budget; a DV in that same cycle still takes priority.
  assign expired = (state_q == StWait) && (cnt_q == CntLast);

  // Count WAIT cycles; flag is sticky until reset.
  always_comb begin
    cnt_d     = (state_q == StWait) ? cnt_q + 1'b1 : '0;
    timeout_d = timeout_q | (expired && !i_p_data_DV);
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expired   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Next-state: arbitration in IDLE, completion capture in WAIT.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    p_write_d   = p_write_q;
    p_address_d = p_address_q;
    p_data_d    = p_data_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    complete    = 1'b0;
    comp_data   = i_p_data;
    case (state_q)
      StIdle: begin
        if (i_a_request || i_b_request) begin
          last_d      = (i_a_request && i_b_request) ? ~last_q : i_b_request;
          p_write_d   = last_d ? i_b_write   : i_a_write;
          p_address_d = last_d ? i_b_address : i_a_address;
          p_data_d    = last_d ? i_b_data    : i_a_data;
          state_d     = StIssue;
        end
      end
      // A DV arriving alongside the request pulse is not a response to it.
      StIssue: state_d = StWait;
      StWait: begin
        if (i_p_data_DV) begin
          complete = 1'b1;
        end else if (expired) begin
          complete  = 1'b1;
          comp_data = '1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (complete) begin
      state_d = StDone;
      if (last_q) b_data_d = comp_data;
      else        a_data_d = comp_data;
    end
  end

  // State, grant history and latched transaction registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      p_write_q   <= 1'b0;
      p_address_q <= '0;
      p_data_q    <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      p_write_q   <= p_write_d;
      p_address_q <= p_address_d;
      p_data_q    <= p_data_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
    end
  end

  assign o_p_request = (state_q == StIssue);
  assign o_p_write   = p_write_q;
  assign o_p_address = p_address_q;
  assign o_p_data    = p_data_q;
  assign o_a_data    = a_data_q;
  assign o_b_data    = b_data_q;
  assign o_a_data_DV = (state_q == StDone) && !last_q;
  assign o_b_data_DV = (state_q == StDone) && last_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized bench for periph_bus_arbiter against a transaction-level reference model.
// Honours PERIPH_TIMEOUT_EN the same way as the design.

module tb_periph_bus_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 15;

  localparam int MIdle   = 0;
  localparam int MRand   = 1;
  localparam int MBoth   = 2;
  localparam int MBOnly  = 3;
  localparam int MAOnce  = 4;
  localparam int MSilent = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_wr, b_req, b_wr, p_dv;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, p_rdata;
  logic [DW-1:0] a_rdata, b_rdata, p_wdata;
  logic          a_dv, b_dv, p_req, p_wr, tmo;
  logic [AW-1:0] p_addr;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_request (a_req),
    .i_a_write   (a_wr),
    .i_a_address (a_addr),
    .i_a_data    (a_wdata),
    .o_a_data    (a_rdata),
    .o_a_data_DV (a_dv),
    .i_b_request (b_req),
    .i_b_write   (b_wr),
    .i_b_address (b_addr),
    .i_b_data    (b_wdata),
    .o_b_data    (b_rdata),
    .o_b_data_DV (b_dv),
    .o_p_request (p_req),
    .o_p_write   (p_wr),
    .o_p_address (p_addr),
    .o_p_data    (p_wdata),
    .i_p_data    (p_rdata),
    .i_p_data_DV (p_dv),
    .o_timeout   (tmo)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one transaction record plus round-robin history.
  bit            busy, cool, last_b, a_once_done;
  int            edge_n = 0;
  int            g, resp_edge;
  logic [AW-1:0] e_addr;
  logic          e_wr;
  logic [DW-1:0] e_wdata, e_a_data, e_b_data;
  bit            e_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy     = 1'b0;
    cool     = 1'b0;
    last_b   = 1'b1;
    e_a_data = '0;
    e_b_data = '0;
    e_to     = 1'b0;
  endtask

  task automatic drive_idle();
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    p_dv  = 0; p_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_p_request"}, p_req, 0);
    check_val({tag, "_p_write"},   p_wr, 0);
    check_val({tag, "_p_address"}, p_addr, 0);
    check_val({tag, "_p_data"},    p_wdata, 0);
    check_val({tag, "_a_dv"},      a_dv, 0);
    check_val({tag, "_b_dv"},      b_dv, 0);
    check_val({tag, "_a_data"},    a_rdata, 0);
    check_val({tag, "_b_data"},    b_rdata, 0);
    check_val({tag, "_timeout"},   tmo, 0);
  endtask

  // One clock: predict from the inputs seen at the edge, compare, then drive the next inputs.
  task automatic step(input int mode);
    bit            exp_preq, exp_adv, exp_bdv, in_txn, done_now;
    logic [DW-1:0] cval;
    @(negedge clk);
    edge_n++;
    exp_preq = 0; exp_adv = 0; exp_bdv = 0; done_now = 0; cval = '0;
    in_txn   = busy;
    if (busy) begin
      // First edge after grant is the issue edge; a response there does not count.
      if (p_dv && edge_n >= g + 2) begin
        done_now = 1; cval = p_rdata;
      end
`ifdef PERIPH_TIMEOUT_EN
      else if (edge_n == g + 1 + TO) begin
        done_now = 1; cval = '1; e_to = 1;
      end
`endif
      if (done_now) begin
        busy = 0;
        cool = 1;
        if (last_b) begin e_b_data = cval; exp_bdv = 1; end
        else        begin e_a_data = cval; exp_adv = 1; end
      end
    end else if (cool) begin
      cool = 0;
    end else if (a_req || b_req) begin
      last_b    = (a_req && b_req) ? !last_b : b_req;
      e_addr    = last_b ? b_addr  : a_addr;
      e_wr      = last_b ? b_wr    : a_wr;
      e_wdata   = last_b ? b_wdata : a_wdata;
      busy      = 1;
      in_txn    = 1;
      exp_preq  = 1;
      g         = edge_n;
      resp_edge = (mode == MRand) ? g + 2 + int'($urandom_range(0, 4)) : g + 2;
    end

    check_val("p_request", p_req, exp_preq);
    check_val("a_dv", a_dv, exp_adv);
    check_val("b_dv", b_dv, exp_bdv);
    check_val("a_data", a_rdata, e_a_data);
    check_val("b_data", b_rdata, e_b_data);
    check_val("timeout", tmo, e_to);
    if (in_txn) begin
      check_val("p_address", p_addr, e_addr);
      check_val("p_write", p_wr, e_wr);
      check_val("p_data", p_wdata, e_wdata);
    end

    // Peripheral: real response, or stray pulses in ISSUE/idle that must be ignored.
    p_dv = 0;
    if (busy && mode != MSilent && edge_n + 1 == resp_edge) begin
      p_dv    = 1;
      p_rdata = (mode == MAOnce) ? 8'h5A : DW'($urandom);
    end else if (busy && edge_n == g && $urandom_range(0, 3) == 0) begin
      p_dv    = 1;
      p_rdata = DW'($urandom);
    end else if (!busy && mode == MRand && $urandom_range(0, 5) == 0) begin
      p_dv    = 1;
      p_rdata = DW'($urandom);
    end

    case (mode)
      MIdle: begin
        a_req = 0; b_req = 0;
      end
      MBoth: begin
        a_req = 1; a_wr = 1; a_addr = AW'(1); a_wdata = 8'h0C;
        b_req = 1; b_wr = 0; b_addr = '0;     b_wdata = DW'($urandom);
      end
      MBOnly: begin
        a_req = 0;
        b_req = 1; b_wr = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
      MAOnce: begin
        if (exp_adv) a_once_done = 1;
        a_req = !a_once_done; a_wr = 0; a_addr = '0; a_wdata = DW'($urandom);
        b_req = 0;
      end
      MSilent: begin
        a_req = 1; a_wr = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
        b_req = 0;
      end
      default: begin
        if (a_req) a_req = exp_adv ? 1'($urandom) : ($urandom_range(0, 15) != 0);
        else       a_req = ($urandom_range(0, 2) == 0);
        if (b_req) b_req = exp_bdv ? 1'($urandom) : ($urandom_range(0, 15) != 0);
        else       b_req = ($urandom_range(0, 2) == 0);
        a_wr = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
        b_wr = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
    endcase
  endtask

  task automatic run(input int mode, input int cycles);
    for (int i = 0; i < cycles; i++) step(mode);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(MBoth, 20);
    run(MIdle, 6);
    a_once_done = 0;
    run(MAOnce, 8);
    run(MBOnly, 16);
    run(MRand, 400);
    run(MSilent, 100);

    // Asynchronous reset in the middle of a cycle, likely mid-transaction.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    p_dv    = 1'b1;
    p_rdata = 8'hEE;
    run(MIdle, 2);
    a_once_done = 0;
    run(MAOnce, 8);
    run(MRand, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
